// File: rtl/rom_copy_engine.sv
// ROM-to-destination copy sequencer: streams a contiguous run of ROM bytes to a
// valid/ready write port, hiding the ROM's one-cycle registered-address latency.
module rom_copy_engine #(
    parameter int ROM_ADDR_WIDTH = 12,
    parameter int DST_ADDR_WIDTH = 13,
    parameter int LEN_WIDTH      = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [ROM_ADDR_WIDTH-1:0] src_base_i,
    input  logic [DST_ADDR_WIDTH-1:0] dst_base_i,
    input  logic [LEN_WIDTH-1:0]      length_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      rom_en_o,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [7:0]                rom_data_i,
    output logic                      wr_valid_o,
    input  logic                      wr_ready_i,
    output logic [DST_ADDR_WIDTH-1:0] wr_addr_o,
    output logic [7:0]                wr_data_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [ROM_ADDR_WIDTH-1:0] src_next_q, src_next_d;
    logic [DST_ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_WIDTH-1:0]      remaining_q, remaining_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            src_next_q  <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            src_next_q  <= src_next_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
        end
    end

    // The first fetch is issued combinationally from start so byte 0 is on
    // rom_data in the first STREAM cycle; later fetches only advance on a
    // handshake, which freezes the ROM address register under backpressure.
    always_comb begin
        state_d     = state_q;
        src_next_d  = src_next_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        busy_o      = (state_q != S_IDLE);
        done_o      = 1'b0;
        rom_en_o    = 1'b0;
        rom_addr_o  = '0;
        wr_valid_o  = 1'b0;
        wr_addr_o   = '0;
        wr_data_o   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (length_i != '0) begin
                        rom_en_o    = 1'b1;
                        rom_addr_o  = src_base_i;
                        src_next_d  = src_base_i + ROM_ADDR_WIDTH'(1);
                        dst_ptr_d   = dst_base_i;
                        remaining_d = length_i;
                        state_d     = S_STREAM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_STREAM: begin
                wr_valid_o = 1'b1;
                wr_addr_o  = dst_ptr_q;
                wr_data_o  = rom_data_i;
                rom_addr_o = src_next_q;
                rom_en_o   = wr_ready_i && (remaining_q > LEN_WIDTH'(1));
                if (wr_ready_i) begin
                    dst_ptr_d   = dst_ptr_q + DST_ADDR_WIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (rom_en_o) begin
                        src_next_d = src_next_q + ROM_ADDR_WIDTH'(1);
                    end
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_copy_engine.sv
// Directed bench for rom_copy_engine with a behavioural registered-address ROM
// attached; every scenario task checks its own cycle-by-cycle expectations.
module tb_rom_copy_engine;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [11:0] srcBase;
    logic [12:0] dstBase;
    logic [11:0] lengthIn;
    logic        busy;
    logic        done;
    logic        romEn;
    logic [11:0] romAddr;
    logic [7:0]  romData;
    logic        wrValid;
    logic        wrReady;
    logic [12:0] wrAddr;
    logic [7:0]  wrData;

    int checks = 0;
    int errors = 0;

    logic [7:0]  romMem [0:4095];
    logic [11:0] romAddrQ = '0;

    always #5 clk = ~clk;

    // ROM model: address register loads only when enabled, array read is combinational.
    always @(posedge clk) begin
        if (romEn) romAddrQ <= romAddr;
    end
    assign romData = romMem[romAddrQ];

    rom_copy_engine #(
        .ROM_ADDR_WIDTH(12),
        .DST_ADDR_WIDTH(13),
        .LEN_WIDTH(12)
    ) dut (
        .clk_i(clk),
        .rst_ni(rstN),
        .start_i(start),
        .src_base_i(srcBase),
        .dst_base_i(dstBase),
        .length_i(lengthIn),
        .busy_o(busy),
        .done_o(done),
        .rom_en_o(romEn),
        .rom_addr_o(romAddr),
        .rom_data_i(romData),
        .wr_valid_o(wrValid),
        .wr_ready_i(wrReady),
        .wr_addr_o(wrAddr),
        .wr_data_o(wrData)
    );

    function automatic logic [7:0] romByte(input int a);
        int t;
        t = ((a * 37) + 11) ^ (a >> 3);
        return t[7:0];
    endfunction

    task automatic test_reset();
        rstN = 1'b0; start = 1'b0; srcBase = '0; dstBase = '0; lengthIn = '0; wrReady = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, romEn, romAddr, wrValid, wrAddr, wrData} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: busy=%b done=%b romEn=%b romAddr=%h wrValid=%b wrAddr=%h wrData=%h, expected all zero",
                     busy, done, romEn, romAddr, wrValid, wrAddr, wrData);
        end
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checks++;
        if ({busy, wrValid, romEn} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_release_idle: busy=%b wrValid=%b romEn=%b, expected 000", busy, wrValid, romEn);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] a;
        logic [12:0] expAddr;
        @(negedge clk);
        start = 1'b1; srcBase = 12'h010; dstBase = 13'h1000; lengthIn = 12'd4; wrReady = 1'b1;
        #1;
        checks++;
        if ({romEn, romAddr, busy} !== {1'b1, 12'h010, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_first_fetch: romEn=%b romAddr=%h busy=%b, expected 1 010 0", romEn, romAddr, busy);
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a = 12'h010 + 12'(k);
            expAddr = 13'h1000 + 13'(k);
            #1;
            checks++;
            if ({wrValid, wrAddr, wrData, busy, done} !== {1'b1, expAddr, romByte(int'(a)), 1'b1, 1'b0}) begin
                errors++;
                $display("[TB] FAIL b2b_write%0d: valid=%b addr=%h data=%h busy=%b done=%b, expected 1 %h %h 1 0",
                         k, wrValid, wrAddr, wrData, busy, done, expAddr, romByte(int'(a)));
            end
            checks++;
            if (romEn !== (k < 3)) begin
                errors++;
                $display("[TB] FAIL b2b_rom_en%0d: romEn=%b, expected %b", k, romEn, (k < 3));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({done, busy, wrValid} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL b2b_done: done=%b busy=%b wrValid=%b, expected 1 1 0", done, busy, wrValid);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL b2b_idle_after: done=%b busy=%b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        logic readyPat [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int idx;
        logic [12:0] expAddr;
        @(negedge clk);
        start = 1'b1; srcBase = 12'h010; dstBase = 13'h1000; lengthIn = 12'd4; wrReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            wrReady = readyPat[c];
            expAddr = 13'h1000 + 13'(idx);
            #1;
            checks++;
            if ({wrValid, wrAddr, wrData} !== {1'b1, expAddr, romByte(16 + idx)}) begin
                errors++;
                $display("[TB] FAIL bp_cycle%0d: valid=%b addr=%h data=%h, expected 1 %h %h",
                         c + 1, wrValid, wrAddr, wrData, expAddr, romByte(16 + idx));
            end
            checks++;
            if (romEn !== (readyPat[c] && (idx < 3))) begin
                errors++;
                $display("[TB] FAIL bp_rom_en%0d: romEn=%b, expected %b", c + 1, romEn, (readyPat[c] && (idx < 3)));
            end
            if (readyPat[c]) idx++;
            @(negedge clk);
        end
        wrReady = 1'b1;
        #1;
        checks++;
        if ({done, wrValid, idx[2:0]} !== {1'b1, 1'b0, 3'd4}) begin
            errors++;
            $display("[TB] FAIL bp_done: done=%b wrValid=%b writes=%0d, expected 1 0 4", done, wrValid, idx);
        end
    endtask

    task automatic test_zero_length();
        @(negedge clk);
        start = 1'b1; srcBase = 12'h055; dstBase = 13'h0123; lengthIn = 12'd0; wrReady = 1'b1;
        #1;
        checks++;
        if ({romEn, romAddr} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL zero_no_fetch: romEn=%b romAddr=%h, expected 0 000", romEn, romAddr);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if ({done, busy, wrValid, romEn} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL zero_done: done=%b busy=%b wrValid=%b romEn=%b, expected 1 1 0 0", done, busy, wrValid, romEn);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({done, busy, wrValid, romEn} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL zero_after: done=%b busy=%b wrValid=%b romEn=%b, expected 0 0 0 0", done, busy, wrValid, romEn);
        end
    endtask

    task automatic test_wrap_around();
        logic [11:0] a;
        logic [11:0] nextA;
        logic [12:0] expAddr;
        @(negedge clk);
        start = 1'b1; srcBase = 12'hFFE; dstBase = 13'h1FFF; lengthIn = 12'd3; wrReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a = 12'hFFE + 12'(k);
            nextA = a + 12'd1;
            expAddr = 13'h1FFF + 13'(k);
            #1;
            checks++;
            if ({wrValid, wrAddr, wrData} !== {1'b1, expAddr, romByte(int'(a))}) begin
                errors++;
                $display("[TB] FAIL wrap_write%0d: valid=%b addr=%h data=%h, expected 1 %h %h",
                         k, wrValid, wrAddr, wrData, expAddr, romByte(int'(a)));
            end
            if (k < 2) begin
                checks++;
                if ({romEn, romAddr} !== {1'b1, nextA}) begin
                    errors++;
                    $display("[TB] FAIL wrap_fetch%0d: romEn=%b romAddr=%h, expected 1 %h", k, romEn, romAddr, nextA);
                end
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_done: done=%b, expected 1", done);
        end
    endtask

    task automatic test_start_while_busy();
        int writes;
        int dones;
        logic [12:0] expAddr;
        @(negedge clk);
        start = 1'b1; srcBase = 12'h020; dstBase = 13'h0400; lengthIn = 12'd4; wrReady = 1'b1;
        writes = 0;
        dones = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start = 1'b1; srcBase = 12'h300; dstBase = 13'h0A00; lengthIn = 12'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            if (wrValid && wrReady) begin
                expAddr = 13'h0400 + 13'(writes);
                checks++;
                if ({wrAddr, wrData} !== {expAddr, romByte(32 + writes)}) begin
                    errors++;
                    $display("[TB] FAIL swb_write%0d: addr=%h data=%h, expected %h %h",
                             writes, wrAddr, wrData, expAddr, romByte(32 + writes));
                end
                writes++;
            end
            if (done) dones++;
        end
        checks++;
        if (writes != 4 || dones != 1) begin
            errors++;
            $display("[TB] FAIL swb_counts: writes=%0d dones=%0d, expected 4 1", writes, dones);
        end
    endtask

    task automatic test_reset_mid_transfer();
        int strayWrites;
        logic [12:0] expAddr;
        @(negedge clk);
        start = 1'b1; srcBase = 12'h100; dstBase = 13'h0800; lengthIn = 12'd8; wrReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checks++;
        if ({busy, done, romEn, romAddr, wrValid, wrAddr, wrData} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs: busy=%b done=%b romEn=%b romAddr=%h wrValid=%b wrAddr=%h wrData=%h, expected all zero",
                     busy, done, romEn, romAddr, wrValid, wrAddr, wrData);
        end
        strayWrites = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) rstN = 1'b1;
            #1;
            if (wrValid || busy) strayWrites++;
        end
        checks++;
        if (strayWrites != 0) begin
            errors++;
            $display("[TB] FAIL midrst_no_writes: active cycles=%0d, expected 0", strayWrites);
        end
        @(negedge clk);
        start = 1'b1; srcBase = 12'h200; dstBase = 13'h0010; lengthIn = 12'd2;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            expAddr = 13'h0010 + 13'(k);
            #1;
            checks++;
            if ({wrValid, wrAddr, wrData} !== {1'b1, expAddr, romByte(512 + k)}) begin
                errors++;
                $display("[TB] FAIL midrst_restart%0d: valid=%b addr=%h data=%h, expected 1 %h %h",
                         k, wrValid, wrAddr, wrData, expAddr, romByte(512 + k));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({done, busy} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL midrst_restart_done: done=%b busy=%b, expected 1 1", done, busy);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) romMem[i] = romByte(i);
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_zero_length();
        test_wrap_around();
        test_start_while_busy();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_copy_engine.md
# rom_copy_engine

Sequencer that drives a `ROM` instance's `en`/`addr` port and streams a contiguous run of ROM bytes into a destination memory (VRAM / tile RAM) over a valid/ready write port. It sits directly upstream of the ROM, issuing addresses, and directly downstream of it, consuming `data_out`. It absorbs the ROM's one-cycle registered-address latency and handles destination backpressure by holding the ROM's address register. It is used at boot to load font and tile data into video memory.

## Interface

- `ROM_ADDR_WIDTH`, 12: width of the ROM address; must match the attached ROM's `ADDRESS_WIDTH`.
- `DST_ADDR_WIDTH`, 13: width of the destination write address.
- `LEN_WIDTH`, 12: width of the transfer byte count.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a transfer; sampled only in IDLE.
- `src_base` in ROM_ADDR_WIDTH: first ROM address; sampled with `start`.
- `dst_base` in DST_ADDR_WIDTH: first destination address; sampled with `start`.
- `length` in LEN_WIDTH: byte count; 0 is a legal no-op. Sampled with `start`.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `rom_en` out 1: connects to the ROM's `en`.
- `rom_addr` out ROM_ADDR_WIDTH: connects to the ROM's `addr`.
- `rom_data` in 8: connects to the ROM's `data_out`.
- `wr_valid` out 1: destination write request.
- `wr_ready` in 1: destination accepts; a write completes on `wr_valid && wr_ready`.
- `wr_addr` out DST_ADDR_WIDTH: destination address.
- `wr_data` out 8: destination data, equal to `rom_data` while in STREAM.

## Operation

- **States:** IDLE, STREAM, DONE.
- **Registers:**
  - `src_next`: next ROM address to fetch.
  - `dst_ptr`: current destination address.
  - `remaining`: bytes not yet written, LEN_WIDTH bits.
- **IDLE:**
  - `start=1` and `length!=0`:
    - drive `rom_en=1` and `rom_addr=src_base` in the same cycle (combinational from `start`);
    - latch `src_next=src_base+1`, `dst_ptr=dst_base`, `remaining=length`;
    - go to STREAM.
  - `start=1` and `length==0`: go to DONE; `rom_en` stays 0 and no write is issued.
  - Otherwise: `rom_en=0`, `rom_addr=0`.
- **STREAM:**
  - Drive `wr_valid=1`, `wr_addr=dst_ptr`, `wr_data=rom_data`.
  - Drive `rom_addr=src_next` and `rom_en = wr_ready && (remaining>1)`.
  - On a handshake: `dst_ptr++`, `remaining--`, and `src_next++` if `rom_en=1`.
  - If `remaining==1` at the handshake, go to DONE.
  - No handshake: all registers hold and `rom_en=0`. Because the ROM freezes its address register, `rom_data` and therefore `wr_data` stay stable, as do `wr_addr` and `wr_valid`.
- **DONE:** `done=1` for exactly one cycle, then IDLE.
- **start handling:** `start` is ignored in STREAM and DONE; there is no queuing.
- **Wrap-around:** `src_next` wraps modulo 2^ROM_ADDR_WIDTH and `dst_ptr` wraps modulo 2^DST_ADDR_WIDTH, with no error. Keeping `src_base+length` within the ROM's MEM_SIZE is the caller's responsibility.
- **Reset:**
  - Assertion of `rst_n` at any time, including mid-transfer, forces IDLE immediately.
  - All outputs go to 0: `busy`, `done`, `rom_en`, `rom_addr`, `wr_valid`, `wr_addr`.
  - `wr_data` reads 0 because it is gated by STREAM.
  - `src_next`, `dst_ptr` and `remaining` reset to 0.
  - No write is issued after reset. The ROM's unreset address register is don't-care.

## Timing

- `start` is accepted at edge T0 (cycle T0 is the IDLE cycle). The first `wr_valid` appears in cycle T0+1.
- With `wr_ready` held high, N bytes are written in cycles T0+1 … T0+N, one byte per cycle, and `done` pulses in cycle T0+N+1.
- `busy` is high in cycles T0+1 … T0+N+1. A new `start` is accepted no earlier than cycle T0+N+2.
- Each cycle of `wr_ready=0` in STREAM adds exactly one cycle to the transfer.
- A `length=0` request: `busy=1` and `done=1` in cycle T0+1 only, with no writes.
- ROM read latency is exactly one clock (registered address, combinational array read). Byte k is fetched in the cycle of handshake k-1 and is presented to the destination on the next cycle.

## Test plan

- **Back-to-back copy:** reset, then `start` with `src_base=0x010`, `dst_base=0x1000`, `length=4`, `wr_ready=1`.
  - Writes at 0x1000–0x1003 carry ROM[0x010..0x013] in cycles T0+1..T0+4.
  - `done` pulses at T0+5; `busy` is high for T0+1..T0+5.
- **Backpressure:** same transfer with `wr_ready` low in cycles T0+2 and T0+3.
  - `wr_addr=0x1001` and `wr_data=ROM[0x011]` hold stable; `rom_en=0` in those cycles.
  - Four writes total, in order; `done` at T0+7.
- **Zero length:** `start` with `length=0`.
  - `done` and `busy` are high in T0+1 only; `wr_valid` and `rom_en` never assert.
- **Wrap-around:** `src_base=0xFFE`, `dst_base=0x1FFF`, `length=3`.
  - Reads from ROM 0xFFE, 0xFFF, 0x000.
  - Writes to 0x1FFF, 0x0000, 0x0001.
- **Start while busy:** pulse `start` in T0+2 of a 4-byte transfer.
  - It is ignored: only 4 writes occur and only one `done` pulse.
- **Reset mid-transfer:** assert `rst_n=0` after the 2nd handshake of an 8-byte transfer.
  - All outputs go to 0 immediately and no further writes occur.
  - After release, a new 2-byte `start` completes normally.
